multi_interval_timer: RTL and testbench



---
 rtl/multi_interval_timer.sv | 232 +++++++++++++++++++++++
 tb/tb_multi_interval_timer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_interval_timer.sv
// Purpose : NUM_CH independent down-counting interval timers sharing one clock prescaler, Avalon-MM slave.
// Latency : readdata is registered, valid one clk after address; irq/irq_ch follow registered TO/ITO combinationally.
// Backpressure: none; every access completes in one cycle (no waitrequest), writes are never stalled.
//
// Ports:
//   clk, reset_n          clock and asynchronous active-low reset
//   address/chipselect/   word-addressed slave port; write = chipselect & ~write_n,
//   write_n/writedata     reads are unstrobed (readdata tracks address every cycle)
//   readdata              registered read mux output
//   irq_ch[n]             TO(n) & ITO(n);  irq = OR of irq_ch
//
// Register map, channel n at word base 4n:
//   +0 STATUS  bit0 TO, bit1 RUN; any write clears TO
//   +1 CONTROL bit0 ITO, bit1 CONT stored; write bit2 START, bit3 STOP (START wins)
//   +2 PERIOD  reload value; a write also forces the counter to reload next cycle and stops it
//   +3 SNAP    any write latches the live counter; read returns the latched value
//   4*NUM_CH   PRESCALE  shared prescaler reload value
module multi_interval_timer #(
  parameter int          NUM_CH       = 4,
  parameter int          COUNT_W      = 32,
  parameter int          ADDR_W       = 5,
  parameter logic [31:0] RESET_PERIOD = 32'h1387F,
  parameter int          PRESCALE_W   = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic              irq,
  output logic [NUM_CH-1:0] irq_ch
);

  localparam logic [COUNT_W-1:0] RST_COUNT     = RESET_PERIOD[COUNT_W-1:0];
  localparam logic [ADDR_W-1:0]  PRESCALE_ADDR = ADDR_W'(4 * NUM_CH);

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic              wr_en;
  logic              wr_prescale;
  logic [NUM_CH-1:0] wr_status;
  logic [NUM_CH-1:0] wr_control;
  logic [NUM_CH-1:0] wr_period;
  logic [NUM_CH-1:0] wr_snap;

  assign wr_en = chipselect & ~write_n;

  always_comb begin
    wr_status   = '0;
    wr_control  = '0;
    wr_period   = '0;
    wr_snap     = '0;
    wr_prescale = wr_en && (address == PRESCALE_ADDR);
    for (int n = 0; n < NUM_CH; n++) begin
      wr_status[n]  = wr_en && (address == ADDR_W'(4 * n));
      wr_control[n] = wr_en && (address == ADDR_W'(4 * n + 1));
      wr_period[n]  = wr_en && (address == ADDR_W'(4 * n + 2));
      wr_snap[n]    = wr_en && (address == ADDR_W'(4 * n + 3));
    end
  end

  // ---------------------------------------------------------------------------
  // Shared prescaler: tick whenever the down-counter sits at zero, then reload.
  // A PRESCALE write zeroes the counter so the very next cycle ticks, which
  // makes the phase of the new rate deterministic for software.
  // ---------------------------------------------------------------------------
  logic [PRESCALE_W-1:0] prescale_q;
  logic [PRESCALE_W-1:0] pcount_q;
  logic                  tick;

  assign tick = (pcount_q == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prescale_q <= '0;
      pcount_q   <= '0;
    end else begin
      if (wr_prescale) begin
        prescale_q <= writedata[PRESCALE_W-1:0];
        pcount_q   <= '0;
      end else if (tick) begin
        pcount_q   <= prescale_q;
      end else begin
        pcount_q   <= pcount_q - PRESCALE_W'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Channel state
  // ---------------------------------------------------------------------------
  logic [NUM_CH-1:0]  to_q, to_d;
  logic [NUM_CH-1:0]  run_q, run_d;
  logic [NUM_CH-1:0]  ito_q, ito_d;
  logic [NUM_CH-1:0]  cont_q, cont_d;
  logic [NUM_CH-1:0]  reload_q, reload_d;   // registered "PERIOD was just written"
  logic [NUM_CH-1:0]  timeout_ev;
  logic [COUNT_W-1:0] period_q [NUM_CH];
  logic [COUNT_W-1:0] period_d [NUM_CH];
  logic [COUNT_W-1:0] count_q  [NUM_CH];
  logic [COUNT_W-1:0] count_d  [NUM_CH];
  logic [COUNT_W-1:0] snap_q   [NUM_CH];
  logic [COUNT_W-1:0] snap_d   [NUM_CH];

  always_comb begin
    to_d       = to_q;
    run_d      = run_q;
    ito_d      = ito_q;
    cont_d     = cont_q;
    reload_d   = wr_period;
    timeout_ev = '0;
    period_d   = period_q;
    count_d    = count_q;
    snap_d     = snap_q;

    for (int n = 0; n < NUM_CH; n++) begin
      // Counter update in priority order: forced reload, timeout, decrement, hold.
      if (reload_q[n]) begin
        count_d[n] = period_q[n];
        run_d[n]   = 1'b0;
      end else if (run_q[n] && tick) begin
        if (count_q[n] == '0) begin
          count_d[n]    = period_q[n];
          timeout_ev[n] = 1'b1;
          if (!cont_q[n]) begin
            run_d[n] = 1'b0;
          end
        end else begin
          count_d[n] = count_q[n] - COUNT_W'(1);
        end
      end

      // CONTROL is applied after the counter logic so that START overrides
      // both the reload-stop and a one-shot expiry landing in the same cycle.
      if (wr_control[n]) begin
        ito_d[n]  = writedata[0];
        cont_d[n] = writedata[1];
        if (writedata[3]) begin
          run_d[n] = 1'b0;
        end
        if (writedata[2]) begin
          run_d[n] = 1'b1;
        end
      end

      // Set dominates clear so a timeout racing a STATUS write is never lost.
      if (wr_status[n]) begin
        to_d[n] = 1'b0;
      end
      if (timeout_ev[n]) begin
        to_d[n] = 1'b1;
      end

      if (wr_period[n]) begin
        period_d[n] = writedata[COUNT_W-1:0];
      end

      // Latch the counter as it stands in the write cycle, before this edge's update.
      if (wr_snap[n]) begin
        snap_d[n] = count_q[n];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      to_q     <= '0;
      run_q    <= '0;
      ito_q    <= '0;
      cont_q   <= '0;
      reload_q <= '0;
      for (int n = 0; n < NUM_CH; n++) begin
        period_q[n] <= RST_COUNT;
        count_q[n]  <= RST_COUNT;
        snap_q[n]   <= '0;
      end
    end else begin
      to_q     <= to_d;
      run_q    <= run_d;
      ito_q    <= ito_d;
      cont_q   <= cont_d;
      reload_q <= reload_d;
      period_q <= period_d;
      count_q  <= count_d;
      snap_q   <= snap_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Interrupts
  // ---------------------------------------------------------------------------
  assign irq_ch = to_q & ito_q;
  assign irq    = |irq_ch;

  // ---------------------------------------------------------------------------
  // Read mux, registered. Unmapped addresses fall through to zero.
  // ---------------------------------------------------------------------------
  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (address == ADDR_W'(4 * n)) begin
        rd_mux = {30'b0, run_q[n], to_q[n]};
      end
      if (address == ADDR_W'(4 * n + 1)) begin
        rd_mux = {30'b0, cont_q[n], ito_q[n]};
      end
      if (address == ADDR_W'(4 * n + 2)) begin
        rd_mux = 32'(period_q[n]);
      end
      if (address == ADDR_W'(4 * n + 3)) begin
        rd_mux = 32'(snap_q[n]);
      end
    end
    if (address == PRESCALE_ADDR) begin
      rd_mux = 32'(prescale_q);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_multi_interval_timer.sv
// Purpose : self-checking bench for multi_interval_timer (32-bit and 16-bit counter builds on one bus).
// Latency : reads compare readdata one clk after the address is presented.
// Backpressure: n/a; the slave never stalls.
module tb_multi_interval_timer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [4:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;
  logic [3:0]  irq_ch;
  logic [31:0] readdata16;
  logic        irq16;
  logic [3:0]  irq_ch16;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  multi_interval_timer #(.NUM_CH(4), .COUNT_W(32), .ADDR_W(5), .RESET_PERIOD(32'h1387F), .PRESCALE_W(16)) u_dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata), .irq(irq), .irq_ch(irq_ch)
  );

  // Narrow-counter build sharing the same bus, used for truncation checks.
  multi_interval_timer #(.NUM_CH(4), .COUNT_W(16), .ADDR_W(5), .RESET_PERIOD(32'h1387F), .PRESCALE_W(16)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect), .write_n(write_n),
    .writedata(writedata), .readdata(readdata16), .irq(irq16), .irq_ch(irq_ch16)
  );

  typedef struct {
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
    logic        chk16;
    logic [31:0] exp16;
  } vec_t;

  vec_t tbl [26];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic bus_read(input logic [4:0] a, output logic [31:0] rd, output logic [31:0] rd16);
    @(negedge clk);
    address    = a;
    chipselect = 1'b0;
    write_n    = 1'b1;
    @(negedge clk);
    rd   = readdata;
    rd16 = readdata16;
  endtask

  // Waits for irq_ch[idx] high at a negedge; returns the edge count at which it was seen.
  task automatic wait_irq(input int idx, input int budget, output int at_cyc);
    at_cyc = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (irq_ch[idx]) begin
        at_cyc = cyc;
        break;
      end
    end
    total++;
    if (at_cyc < 0) begin
      bad++;
      $display("FAIL wait_irq ch%0d: no interrupt within %0d cycles", idx, budget);
    end
  endtask

  task automatic set_vec(input int i, input logic wr, input logic [4:0] a, input logic [31:0] d,
                         input logic [31:0] e, input logic c16, input logic [31:0] e16);
    tbl[i].wr    = wr;
    tbl[i].addr  = a;
    tbl[i].data  = d;
    tbl[i].exp   = e;
    tbl[i].chk16 = c16;
    tbl[i].exp16 = e16;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, rd16;
    int          e, at, r1, r2, r3, s, snap_exp, irq_seen;

    // register-map vectors: {wr, addr, wdata, expected read, check 16-bit build, expected 16-bit read}
    set_vec( 0, 0,  0, 0,            32'h0,        0, 0);          // STATUS ch0 reset
    set_vec( 1, 0,  1, 0,            32'h0,        0, 0);          // CONTROL ch0 reset
    set_vec( 2, 0,  2, 0,            32'h0001387F, 1, 32'h387F);   // PERIOD reset value, truncated in 16-bit build
    set_vec( 3, 0, 14, 0,            32'h0001387F, 0, 0);          // PERIOD ch3 reset
    set_vec( 4, 0,  3, 0,            32'h0,        0, 0);          // SNAP reset
    set_vec( 5, 0, 16, 0,            32'h0,        0, 0);          // PRESCALE reset
    set_vec( 6, 0, 17, 0,            32'h0,        0, 0);          // unmapped 4*NUM_CH+1
    set_vec( 7, 1, 16, 32'hFFFFFFFF, 0,            0, 0);
    set_vec( 8, 0, 16, 0,            32'h0000FFFF, 0, 0);          // prescale zero-extended
    set_vec( 9, 1, 16, 32'h0,        0,            0, 0);
    set_vec(10, 0, 16, 0,            32'h0,        0, 0);
    set_vec(11, 1, 17, 32'h55,       0,            0, 0);          // unmapped write ignored
    set_vec(12, 0, 17, 0,            32'h0,        0, 0);
    set_vec(13, 1,  6, 32'hABCD1234, 0,            0, 0);
    set_vec(14, 0,  6, 0,            32'hABCD1234, 1, 32'h1234);   // period truncation in 16-bit build
    set_vec(15, 1, 13, 32'hC,        0,            0, 0);          // START|STOP together
    set_vec(16, 0, 12, 0,            32'h2,        0, 0);          // RUN=1, START wins
    set_vec(17, 1, 13, 32'h8,        0,            0, 0);          // STOP
    set_vec(18, 0, 12, 0,            32'h0,        0, 0);
    set_vec(19, 1, 13, 32'hF,        0,            0, 0);
    set_vec(20, 0, 12, 0,            32'h2,        0, 0);
    set_vec(21, 0, 13, 0,            32'h3,        0, 0);          // CONT, ITO stored
    set_vec(22, 1, 13, 32'h8,        0,            0, 0);
    set_vec(23, 0, 12, 0,            32'h0,        0, 0);
    set_vec(24, 0, 13, 0,            32'h0,        0, 0);
    set_vec(25, 0, 31, 0,            32'h0,        0, 0);          // top unmapped

    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    repeat (3) @(negedge clk);
    check("reset_readdata", readdata, 0);
    check("reset_irq", {31'b0, irq}, 0);
    check("reset_irq_ch", {28'b0, irq_ch}, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 26; i++) begin
      if (tbl[i].wr) begin
        bus_write(tbl[i].addr, tbl[i].data);
      end else begin
        bus_read(tbl[i].addr, rd, rd16);
        check($sformatf("vec%0d", i), rd, tbl[i].exp);
        if (tbl[i].chk16) check($sformatf("vec%0d_w16", i), rd16, tbl[i].exp16);
      end
    end

    // Continuous ch0, period 9, prescale 0: TO on the 11th edge counting START, then every 10.
    bus_write(2, 9);
    bus_write(1, 32'h7);
    e = cyc;
    for (int k = 1; k <= 3; k++) begin
      wait_irq(0, 30, at);
      check($sformatf("cont_interval%0d", k), at - e, 10 * k);
      if (k == 1) begin
        bus_read(0, rd, rd16);
        check("cont_status", rd, 32'h3);
      end
      bus_write(0, 0);
      if (k == 1) check("cont_clear_irq", {31'b0, irq_ch[0]}, 0);
    end
    bus_write(1, 32'h8);
    bus_write(0, 0);
    check("ch0_stopped_irq", {31'b0, irq}, 0);

    // One-shot ch1, period 4.
    bus_write(6, 4);
    bus_write(5, 32'h5);
    e = cyc;
    wait_irq(1, 20, at);
    check("oneshot_latency", at - e, 5);
    repeat (10) @(negedge clk);
    check("oneshot_irq_held", {31'b0, irq_ch[1]}, 1);
    bus_read(4, rd, rd16);
    check("oneshot_status", rd, 32'h1);
    bus_write(7, 0);
    bus_read(7, rd, rd16);
    check("oneshot_counter_hold", rd, 4);
    bus_write(5, 0);
    check("ito_clear_irq", {31'b0, irq}, 0);
    bus_read(4, rd, rd16);
    check("ito_clear_to_kept", rd, 32'h1);
    bus_write(5, 1);
    check("ito_set_irq", {31'b0, irq_ch[1]}, 1);
    bus_write(4, 0);
    check("status_write_irq", {31'b0, irq_ch[1]}, 0);
    bus_read(4, rd, rd16);
    check("status_after_clear", rd, 0);

    // Prescale 3, ch2 period 2 continuous: timeout every 12 clks.
    bus_write(16, 3);
    bus_write(10, 2);
    bus_write(9, 32'h7);
    wait_irq(2, 40, r1);
    bus_write(8, 0);
    wait_irq(2, 40, r2);
    check("presc_interval1", r2 - r1, 12);
    // Counter is reloaded to 2 at r2 and steps down on every 4th edge.
    repeat (3) @(negedge clk);
    bus_write(11, 0);
    s = cyc;
    snap_exp = 2 - (s - 1 - r2) / 4;
    bus_read(11, rd, rd16);
    check("presc_snap", rd, snap_exp);
    bus_write(8, 0);
    wait_irq(2, 40, r3);
    check("presc_interval2", r3 - r2, 12);

    // Race: STATUS write sampled on the same edge as the next timeout (r3+12).
    bus_write(8, 0);
    check("race_pre_clear", {31'b0, irq_ch[2]}, 0);
    while (cyc < r3 + 11) @(negedge clk);
    address    = 5'd8;
    writedata  = 0;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    check("race_edge", cyc, r3 + 12);
    check("race_to_kept", {31'b0, irq_ch[2]}, 1);
    bus_read(8, rd, rd16);
    check("race_status", rd, 32'h3);

    // PERIOD write while running: RUN still 1 after the write edge, 0 one edge later.
    bus_write(10, 7);
    address = 5'd8;
    @(negedge clk);
    check("pwr_run_w1", {31'b0, readdata[1]}, 1);
    @(negedge clk);
    check("pwr_run_w2", {31'b0, readdata[1]}, 0);
    bus_write(11, 0);
    bus_read(11, rd, rd16);
    check("pwr_counter", rd, 7);

    // Asynchronous reset mid-count.
    bus_write(1, 32'h7);
    repeat (4) @(negedge clk);
    address = 5'd10;
    @(negedge clk);
    check("pre_reset_read", readdata, 7);
    check("pre_reset_irq", {31'b0, irq}, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_readdata", readdata, 0);
    check("async_reset_irq", {31'b0, irq}, 0);
    check("async_reset_irq_ch", {28'b0, irq_ch}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    irq_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (irq) irq_seen++;
    end
    check("post_reset_no_irq", irq_seen, 0);
    bus_read(10, rd, rd16);
    check("post_reset_period", rd, 32'h0001387F);
    check("post_reset_period_w16", rd16, 32'h387F);
    bus_read(0, rd, rd16);
    check("post_reset_status", rd, 0);
    bus_read(16, rd, rd16);
    check("post_reset_prescale", rd, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
